// File: rtl/ram_128x16_bist.sv
// ram_128x16_bist: March C- memory BIST controller for the 128x16 RAM wrapper.
//
// Runs one March C- pass (w0; r0w1; r1w0; down r0w1; down r1w0; down r0) over
// addresses 0..WORDS-1 each time start is accepted. It reports sticky done and
// fail flags, the address and XOR syndrome of the first mismatch, and a
// saturating mismatch count. The wrapper's test_mode must be held 0 externally
// while a run is in progress.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   start      in   request one BIST run (ignored while busy)
//   dout       in   RAM read data, valid in the cycle after an oe strobe
//   a          out  RAM address
//   din        out  RAM write data
//   wr         out  one-cycle write strobe
//   oe         out  one-cycle read strobe
//   busy       out  run in progress
//   done       out  run complete, held until the next accepted start
//   fail       out  at least one mismatch seen, held until the next accepted start
//   fail_addr  out  address of the first mismatch
//   fail_data  out  expected XOR read data at the first mismatch
//   err_count  out  mismatch count, saturating at 255
//
// Per-address cost: M0 1 cycle (write), M1-M4 3 cycles (issue, check, write),
// M5 2 cycles (issue, check). For WORDS=128 a run lasts 1920 cycles.

module ram_128x16_bist #(
    parameter int unsigned          ADDRSIZE = 7,
    parameter int unsigned          DATASIZE = 16,
    parameter int unsigned          WORDS    = 128,
    parameter logic [DATASIZE-1:0]  PATTERN  = 16'h0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DATASIZE-1:0] dout,
    output logic [ADDRSIZE-1:0] a,
    output logic [DATASIZE-1:0] din,
    output logic                wr,
    output logic                oe,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [ADDRSIZE-1:0] fail_addr,
    output logic [DATASIZE-1:0] fail_data,
    output logic [7:0]          err_count
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;
    typedef enum logic [1:0] {OpWrite, OpRead, OpCheck} op_t;

    localparam logic [ADDRSIZE-1:0] LAST_ADDR = ADDRSIZE'(WORDS - 1);
    localparam logic [2:0]          LAST_ELEM = 3'd5;
    localparam logic [DATASIZE-1:0] BG0       = PATTERN;
    localparam logic [DATASIZE-1:0] BG1       = ~PATTERN;

    state_t                state_q, state_d;
    op_t                   op_q, op_d;
    logic [2:0]            elem_q, elem_d;
    logic [ADDRSIZE-1:0]   addr_q, addr_d;

    logic                  descending;
    logic                  last_addr;
    logic                  advance;
    logic                  start_ok;
    logic                  check_now;
    logic [DATASIZE-1:0]   exp_data;
    logic [DATASIZE-1:0]   diff;
    logic                  mismatch;

    logic [ADDRSIZE-1:0]   a_d;
    logic [DATASIZE-1:0]   din_d;
    logic                  wr_d;
    logic                  oe_d;

    // M3..M5 walk the address space downwards.
    assign descending = (elem_q >= 3'd3);
    assign last_addr  = descending ? (addr_q == '0) : (addr_q == LAST_ADDR);

    assign start_ok   = start && (state_q != StRun);
    assign check_now  = (state_q == StRun) && (op_q == OpCheck);

    // Reads in M1, M3, M5 expect background 0; M2, M4 expect background 1.
    assign exp_data   = elem_q[0] ? BG0 : BG1;
    assign diff       = dout ^ exp_data;
    assign mismatch   = |diff;

    // Next-state sequencing: element, address and op sub-state.
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        addr_d  = addr_q;
        op_d    = op_q;
        advance = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    elem_d  = 3'd0;
                    addr_d  = '0;
                    op_d    = OpWrite;
                end
            end
            StRun: begin
                unique case (op_q)
                    OpRead:  op_d = OpCheck;
                    OpCheck: begin
                        // M5 has no trailing write; the others write right after the check.
                        if (elem_q == LAST_ELEM) begin
                            advance = 1'b1;
                        end else begin
                            op_d = OpWrite;
                        end
                    end
                    default: advance = 1'b1;
                endcase
            end
            default: state_d = StIdle;
        endcase

        if (advance) begin
            if (last_addr) begin
                if (elem_q == LAST_ELEM) begin
                    state_d = StDone;
                    elem_d  = 3'd0;
                    addr_d  = '0;
                    op_d    = OpWrite;
                end else begin
                    elem_d = elem_q + 3'd1;
                    // Entering M3 or later starts at the top address.
                    addr_d = (elem_q >= 3'd2) ? LAST_ADDR : '0;
                    op_d   = OpRead;
                end
            end else begin
                addr_d = descending ? (addr_q - 1'b1) : (addr_q + 1'b1);
                op_d   = (elem_q == 3'd0) ? OpWrite : OpRead;
            end
        end
    end

    // RAM-side outputs for the cycle that the next state describes.
    always_comb begin
        a_d   = '0;
        din_d = '0;
        wr_d  = 1'b0;
        oe_d  = 1'b0;
        if (state_d == StRun) begin
            a_d  = addr_d;
            wr_d = (op_d == OpWrite);
            oe_d = (op_d == OpRead);
            if (op_d == OpWrite) begin
                // M0, M2, M4 write background 0; M1, M3 write background 1.
                din_d = elem_d[0] ? BG1 : BG0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= OpWrite;
            elem_q    <= 3'd0;
            addr_q    <= '0;
            a         <= '0;
            din       <= '0;
            wr        <= 1'b0;
            oe        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            err_count <= 8'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            a       <= a_d;
            din     <= din_d;
            wr      <= wr_d;
            oe      <= oe_d;
            busy    <= (state_d == StRun);
            done    <= (state_d == StDone);

            if (start_ok) begin
                fail      <= 1'b0;
                fail_addr <= '0;
                fail_data <= '0;
                err_count <= 8'd0;
            end else if (check_now && mismatch) begin
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
                // Only the first mismatch of a run is captured.
                if (!fail) begin
                    fail      <= 1'b1;
                    fail_addr <= addr_q;
                    fail_data <= diff;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_128x16_bist.sv
// Bench for ram_128x16_bist. The expected March C- bus sequence is queued when a
// run is started and popped one entry per busy cycle by a negedge monitor.
module tb_ram_128x16_bist;

    typedef struct packed {
        logic        wr;
        logic        oe;
        logic [6:0]  a;
        logic [15:0] din;
    } bus_op_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    // Instance 1: PATTERN 16'h0000 with fault-injecting RAM model
    logic        start1 = 1'b0;
    logic [15:0] dout1;
    logic [6:0]  a1;
    logic [15:0] din1;
    logic        wr1, oe1, busy1, done1, fail1;
    logic [6:0]  fail_addr1;
    logic [15:0] fail_data1;
    logic [7:0]  err_count1;

    // Instance 2: PATTERN 16'hA5A5 with clean RAM model
    logic        start2 = 1'b0;
    logic [15:0] dout2;
    logic [6:0]  a2;
    logic [15:0] din2;
    logic        wr2, oe2, busy2, done2, fail2;
    logic [6:0]  fail_addr2;
    logic [15:0] fail_data2;
    logic [7:0]  err_count2;

    logic [15:0] mem1 [128];
    logic [15:0] mem2 [128];
    int          fault_mode = 0;  // 0 none, 1 bit3 stuck-at-1 @05, 2 all reads inverted

    bus_op_t     sb[$];
    bus_op_t     mon_e;
    logic        mon_en = 1'b0;

    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    ram_128x16_bist dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start1),
        .dout      (dout1),
        .a         (a1),
        .din       (din1),
        .wr        (wr1),
        .oe        (oe1),
        .busy      (busy1),
        .done      (done1),
        .fail      (fail1),
        .fail_addr (fail_addr1),
        .fail_data (fail_data1),
        .err_count (err_count1)
    );

    ram_128x16_bist #(.PATTERN(16'hA5A5)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .start     (start2),
        .dout      (dout2),
        .a         (a2),
        .din       (din2),
        .wr        (wr2),
        .oe        (oe2),
        .busy      (busy2),
        .done      (done2),
        .fail      (fail2),
        .fail_addr (fail_addr2),
        .fail_data (fail_data2),
        .err_count (err_count2)
    );

    // Synchronous-read RAM models: data appears the cycle after oe.
    always @(posedge clk) begin
        if (wr1) mem1[a1] <= din1;
        if (oe1) begin
            if (fault_mode == 2)                     dout1 <= ~mem1[a1];
            else if (fault_mode == 1 && a1 == 7'h05) dout1 <= mem1[a1] | 16'h0008;
            else                                     dout1 <= mem1[a1];
        end
    end

    always @(posedge clk) begin
        if (wr2) mem2[a2] <= din2;
        if (oe2) dout2 <= mem2[a2];
    end

    function automatic bus_op_t mk_op(input logic w, input logic o, input int ad,
                                      input logic [15:0] d);
        bus_op_t r;
        r.wr  = w;
        r.oe  = o;
        r.a   = 7'(ad);
        r.din = d;
        return r;
    endfunction

    // Reference March C- sequence, one entry per run cycle.
    task automatic push_march(input logic [15:0] pat);
        logic [15:0] b0, b1;
        b0 = pat;
        b1 = ~pat;
        for (int i = 0; i < 128; i++) sb.push_back(mk_op(1'b1, 1'b0, i, b0));
        for (int i = 0; i < 128; i++) begin
            sb.push_back(mk_op(1'b0, 1'b1, i, 16'h0));
            sb.push_back(mk_op(1'b0, 1'b0, i, 16'h0));
            sb.push_back(mk_op(1'b1, 1'b0, i, b1));
        end
        for (int i = 0; i < 128; i++) begin
            sb.push_back(mk_op(1'b0, 1'b1, i, 16'h0));
            sb.push_back(mk_op(1'b0, 1'b0, i, 16'h0));
            sb.push_back(mk_op(1'b1, 1'b0, i, b0));
        end
        for (int i = 127; i >= 0; i--) begin
            sb.push_back(mk_op(1'b0, 1'b1, i, 16'h0));
            sb.push_back(mk_op(1'b0, 1'b0, i, 16'h0));
            sb.push_back(mk_op(1'b1, 1'b0, i, b1));
        end
        for (int i = 127; i >= 0; i--) begin
            sb.push_back(mk_op(1'b0, 1'b1, i, 16'h0));
            sb.push_back(mk_op(1'b0, 1'b0, i, 16'h0));
            sb.push_back(mk_op(1'b1, 1'b0, i, b0));
        end
        for (int i = 127; i >= 0; i--) begin
            sb.push_back(mk_op(1'b0, 1'b1, i, 16'h0));
            sb.push_back(mk_op(1'b0, 1'b0, i, 16'h0));
        end
    endtask

    // Scoreboard consumer for instance 1.
    always @(negedge clk) begin
        if (mon_en && busy1 === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: busy=1 but no expected op left");
            end else begin
                mon_e = sb.pop_front();
                if (wr1 !== mon_e.wr || oe1 !== mon_e.oe ||
                    ((mon_e.wr || mon_e.oe) && a1 !== mon_e.a) ||
                    (mon_e.wr && din1 !== mon_e.din)) begin
                    n_err++;
                    $display("FAIL bus_op: got wr=%b oe=%b a=%h din=%h, want wr=%b oe=%b a=%h din=%h",
                             wr1, oe1, a1, din1, mon_e.wr, mon_e.oe, mon_e.a, mon_e.din);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy1, done1, fail1, wr1, oe1} !== 5'b0 || a1 !== 7'h0 || din1 !== 16'h0 ||
            fail_addr1 !== 7'h0 || fail_data1 !== 16'h0 || err_count1 !== 8'h0) begin
            n_err++;
            $display("FAIL reset_outputs1: busy=%b done=%b fail=%b wr=%b oe=%b a=%h din=%h fa=%h fd=%h ec=%0d, want all 0",
                     busy1, done1, fail1, wr1, oe1, a1, din1, fail_addr1, fail_data1, err_count1);
        end
        n_cmp++;
        if ({busy2, done2, fail2, wr2, oe2} !== 5'b0 || a2 !== 7'h0 || din2 !== 16'h0 ||
            err_count2 !== 8'h0) begin
            n_err++;
            $display("FAIL reset_outputs2: busy=%b done=%b fail=%b wr=%b oe=%b a=%h din=%h, want all 0",
                     busy2, done2, fail2, wr2, oe2, a2, din2);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            n_err++;
            $display("FAIL idle_wait: busy=%b done=%b, want 0 0", busy1, done1);
        end
    endtask

    // Starts a run on instance 1 with a one-cycle pulse, checks length and result flags.
    task automatic test_run(input string name, input int fm, input logic exp_fail,
                            input logic [6:0] exp_fa, input logic [15:0] exp_fd,
                            input logic [7:0] exp_ec);
        int cnt;
        fault_mode = fm;
        push_march(16'h0000);
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cnt = 0;
        while (busy1 === 1'b1 && cnt < 4000) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (cnt != 1920) begin
            n_err++;
            $display("FAIL %s_busy_len: got %0d cycles, want 1920", name, cnt);
        end
        n_cmp++;
        if (done1 !== 1'b1 || fail1 !== exp_fail || err_count1 !== exp_ec) begin
            n_err++;
            $display("FAIL %s_result: done=%b fail=%b ec=%0d, want done=1 fail=%b ec=%0d",
                     name, done1, fail1, err_count1, exp_fail, exp_ec);
        end
        n_cmp++;
        if (fail_addr1 !== exp_fa || fail_data1 !== exp_fd) begin
            n_err++;
            $display("FAIL %s_capture: fa=%h fd=%h, want fa=%h fd=%h",
                     name, fail_addr1, fail_data1, exp_fa, exp_fd);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_sb_left: %0d ops unconsumed, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid_run();
        int cnt;
        fault_mode = 0;
        push_march(16'h0000);
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cnt = 0;
        while (busy1 === 1'b1 && cnt < 500) begin
            cnt++;
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy1, done1, fail1, wr1, oe1} !== 5'b0 || a1 !== 7'h0 || din1 !== 16'h0 ||
            fail_addr1 !== 7'h0 || fail_data1 !== 16'h0 || err_count1 !== 8'h0) begin
            n_err++;
            $display("FAIL midrun_reset: busy=%b done=%b fail=%b wr=%b oe=%b a=%h din=%h ec=%0d, want all 0",
                     busy1, done1, fail1, wr1, oe1, a1, din1, err_count1);
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_idle: busy=%b, want 0", busy1);
        end
        test_run("after_reset", 0, 1'b0, 7'h00, 16'h0000, 8'd0);
    endtask

    task automatic test_start_held();
        int cnt;
        int guard;
        fault_mode = 0;
        push_march(16'h0000);
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        cnt = 0;
        guard = 0;
        while (done1 !== 1'b1 && guard < 4000) begin
            if (busy1 === 1'b1) cnt++;
            guard++;
            @(negedge clk);
        end
        start1 = 1'b0;
        n_cmp++;
        if (cnt != 1920 || guard != 1920) begin
            n_err++;
            $display("FAIL held_len: busy=%0d cycles over %0d, want 1920 over 1920", cnt, guard);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy1 !== 1'b0 || done1 !== 1'b1 || sb.size() != 0) begin
            n_err++;
            $display("FAIL held_single_run: busy=%b done=%b sb=%0d, want 0 1 0",
                     busy1, done1, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_restart_after_done();
        int cnt;
        push_march(16'h0000);
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n_cmp++;
        if (done1 !== 1'b0 || busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL restart_edge: done=%b busy=%b, want 0 1", done1, busy1);
        end
        cnt = 0;
        while (busy1 === 1'b1 && cnt < 4000) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (cnt != 1920 || done1 !== 1'b1 || fail1 !== 1'b0) begin
            n_err++;
            $display("FAIL restart_run: len=%0d done=%b fail=%b, want 1920 1 0",
                     cnt, done1, fail1);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL restart_sb_left: %0d, want 0", sb.size());
            sb.delete();
        end
    endtask

    // Instance 2 checked at fixed run cycles: 0 first M0 write, 130 first M1
    // write, 896 first M3 read, 1918 last M5 read.
    task automatic test_pattern();
        int cnt;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cnt = 0;
        while (busy2 === 1'b1 && cnt < 4000) begin
            if (cnt == 0) begin
                n_cmp++;
                if (wr2 !== 1'b1 || a2 !== 7'h00 || din2 !== 16'hA5A5) begin
                    n_err++;
                    $display("FAIL pat_m0_write: wr=%b a=%h din=%h, want 1 00 a5a5", wr2, a2, din2);
                end
            end
            if (cnt == 130) begin
                n_cmp++;
                if (wr2 !== 1'b1 || a2 !== 7'h00 || din2 !== 16'h5A5A) begin
                    n_err++;
                    $display("FAIL pat_m1_write: wr=%b a=%h din=%h, want 1 00 5a5a", wr2, a2, din2);
                end
            end
            if (cnt == 896) begin
                n_cmp++;
                if (oe2 !== 1'b1 || wr2 !== 1'b0 || a2 !== 7'h7F) begin
                    n_err++;
                    $display("FAIL pat_m3_first: oe=%b wr=%b a=%h, want 1 0 7f", oe2, wr2, a2);
                end
            end
            if (cnt == 1918) begin
                n_cmp++;
                if (oe2 !== 1'b1 || wr2 !== 1'b0 || a2 !== 7'h00) begin
                    n_err++;
                    $display("FAIL pat_m5_last: oe=%b wr=%b a=%h, want 1 0 00", oe2, wr2, a2);
                end
            end
            cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (cnt != 1920 || done2 !== 1'b1 || fail2 !== 1'b0 || err_count2 !== 8'd0 ||
            fail_addr2 !== 7'h00 || fail_data2 !== 16'h0000) begin
            n_err++;
            $display("FAIL pat_result: len=%0d done=%b fail=%b ec=%0d, want 1920 1 0 0",
                     cnt, done2, fail2, err_count2);
        end
    endtask

    initial begin
        mon_en = 1'b1;
        test_reset();
        test_run("clean", 0, 1'b0, 7'h00, 16'h0000, 8'd0);
        test_run("stuck_bit3", 1, 1'b1, 7'h05, 16'h0008, 8'd3);
        test_reset_mid_run();
        test_start_held();
        test_restart_after_done();
        test_run("saturate", 2, 1'b1, 7'h00, 16'hFFFF, 8'd255);
        test_pattern();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_128x16_bist.md
RAM_128X16_BIST -- requirements
Module: ram_128x16_bist

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 7: RAM address width.
REQ-002 SHALL have parameter DATASIZE, default 16: RAM data width.
REQ-003 SHALL have parameter WORDS, default 128: number of words tested, addresses 0..WORDS-1.
REQ-004 SHALL have parameter PATTERN, default 16'h0000: data background "0"; background "1" is ~PATTERN.
REQ-005 SHALL have one clock and an asynchronous, active-high reset; all other ports follow.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request one BIST run
- dout  input  DATASIZE  RAM read data
- a  output  ADDRSIZE  RAM address
- din  output  DATASIZE  RAM write data
- wr  output  1  one-cycle write strobe
- oe  output  1  one-cycle read strobe
- busy  output  1  run in progress
- done  output  1  run complete, sticky
- fail  output  1  at least one mismatch, sticky
- fail_addr  output  ADDRSIZE  address of first mismatch
- fail_data  output  DATASIZE  XOR of expected and read data at first mismatch
- err_count  output  8  mismatch count, saturating at 255

Function
REQ-006 SHALL act as the initiator for the 128x16 RAM wrapper; wrapper test_mode SHALL be held 0 externally during a run.
REQ-007 SHALL execute March C- in order:
- M0 ascending w0
- M1 ascending r0,w1
- M2 ascending r1,w0
- M3 descending r0,w1
- M4 descending r1,w0
- M5 descending r0
REQ-008 Write op: one cycle, wr=1, oe=0, a and din valid in that cycle.
REQ-009 Read op: issue cycle (oe=1, wr=0, a valid), then check cycle (oe=0); dout sampled and compared at the check cycle.
REQ-010 In a read-then-write element, the write to the same address SHALL follow immediately after the check cycle.
REQ-011 Per address, cycle cost SHALL be: M0 1, M1-M4 3, M5 2; total run length SHALL be 1920 cycles for WORDS=128.
REQ-012 FSM states SHALL be IDLE, RUN (element and op sub-state), DONE.
- IDLE->RUN on start=1.
- RUN->DONE after the last M5 check at address 0.
- DONE->RUN on start=1.
REQ-013 busy SHALL be 1 for exactly the 1920 RUN cycles, starting the cycle after start is sampled.
REQ-014 done SHALL rise in the cycle after the last check and hold until the next accepted start.
REQ-015 start SHALL be ignored while busy=1.
REQ-016 An accepted start SHALL clear done, fail, fail_addr, fail_data and err_count.
REQ-017 On mismatch:
- err_count increments, saturating at 255.
- If fail=0: fail=1, and fail_addr/fail_data capture that check.
- Later mismatches SHALL NOT change fail_addr or fail_data.
REQ-018 The run SHALL continue to completion after a mismatch.
REQ-019 Ascending elements SHALL wrap from WORDS-1 to the next element; descending elements SHALL run from WORDS-1 to 0.
REQ-020 Outside RUN: wr=0, oe=0, a=0, din=0.

Reset
REQ-021 reset=1 SHALL asynchronously force IDLE and clear all outputs to 0, including mid-run.
REQ-022 After reset deasserts, the block SHALL wait for start.

Verification
REQ-023 Bench SHALL cover these scenarios:
- Fault-free RAM model, 1-cycle start pulse -> busy high 1920 cycles, then done=1, fail=0, err_count=0.
- Bit 3 stuck-at-1 at address 7'h05 -> fail=1, fail_addr=7'h05, fail_data=16'h0008, err_count=3.
- reset pulsed at run cycle 500 -> all outputs 0 immediately; next start completes a clean 1920-cycle run.
- start held high throughout -> exactly one run, busy never re-asserts before done. Then start after done -> done clears one cycle later and a new run begins.
- PATTERN=16'hA5A5 -> M0 writes din=16'hA5A5, M1 writes 16'h5A5A. First M3 op is a read at a=7'h7F; last M5 read is at a=7'h00.
- Every address faulty, all reads mismatching -> err_count saturates at 255, fail_addr=7'h00 (first M1 check).
